pipe_issue_arbiter: RTL and testbench
=====================================

# pipe_issue_arbiter

Issue controller for the 3-stage ALU/multiply pipeline. It arbitrates two requesters onto the single `valid_in`/`data_in` issue port and tracks in-flight operations with a tag shift register, so each pipeline result returns to the requester that issued it. It also counts operations lost to pipeline flushes (force resets) and implements a drain/halt handshake for software quiesce.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `PIPE_LATENCY`, 4: cycles from `pipe_valid_in` to `pipe_valid_out` (3 stages + output register); legal range 2..8.
- `CNT_WIDTH`, 16: width of `drop_count`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 operand valid.
- `req0_data` in DATA_WIDTH: requester 0 operand.
- `req0_ready` out 1: requester 0 accepted this cycle (combinational).
- `req1_valid`, `req1_data`, `req1_ready`: same, requester 1.
- `pipe_valid_in` out 1: issue strobe to the pipeline (registered).
- `pipe_data_in` out DATA_WIDTH: issued operand (registered).
- `pipe_valid_out` in 1: pipeline result valid.
- `pipe_data_out` in DATA_WIDTH: pipeline result.
- `pipe_flush` in 1: pipeline force-reset indication.
- `resp0_valid`, `resp1_valid` out 1: result for requester 0/1 (registered).
- `resp_data` out DATA_WIDTH: result data (registered).
- `drain_req` in 1: level request to stop issuing.
- `drain_done` out 1: high in HALT.
- `state` out 2: 0 RUN, 1 DRAIN, 2 HALT.
- `drop_count` out CNT_WIDTH: saturating count of flushed in-flight ops.
- `sync_err` out 1: sticky tag/result mismatch flag.

## Operation
- Reset: every output is 0; state RUN; tag register empty; RR pointer favours requester 0.
- Readiness: `reqN_ready = (state==RUN) && !drain_req && grant==N`. At most one grant per cycle.
- Handshake: `reqN_valid && reqN_ready` in cycle T drives `pipe_valid_in=1` and `pipe_data_in=reqN_data` in T+1. Otherwise `pipe_valid_in=0` and `pipe_data_in` holds its value.
- Tag register: PIPE_LATENCY entries of {valid, id}. It shifts every cycle, and entry 0 is loaded from the issue register.
- Result matching: a tail entry with valid=1 is matched against `pipe_valid_out`. On a match, the next cycle gives `resp<id>_valid=1` and `resp_data=pipe_data_out`.
- Mismatch: tail valid ≠ `pipe_valid_out` sets `sync_err`, which is cleared only by `rst`. No response is produced for an unmatched `pipe_valid_out`.
- Flush: on `pipe_flush=1`, all tag entries are invalidated, including any issue in that same cycle. `drop_count` increases by the popcount of the invalidated entries and saturates at all-ones. Pipeline results arriving in the same cycle as a flush are dropped.
- FSM:
  - RUN→DRAIN when `drain_req=1`.
  - DRAIN→HALT when the tag register and issue register are both empty.
  - HALT→RUN when `drain_req=0`.
  - DRAIN→RUN when `drain_req` drops before empty.
  - A flush in DRAIN empties the tag register, so the FSM goes to HALT the next cycle.
- `rst` mid-operation aborts everything immediately: tags are cleared and `drop_count` and `sync_err` are zeroed.

## Timing
- Accept in T, then issue in T+1, `pipe_valid_out` in T+1+PIPE_LATENCY, response in T+2+PIPE_LATENCY (T+6 at default).
- Throughput: one issue per cycle. Back-to-back responses are allowed.
- `drain_req` rising in T blocks acceptance in T. `drain_done` rises the first cycle after the last response's tag retires.

## Configuration
- `PIPE_ARB_RR_EN` defined: round-robin arbitration. After a grant to N, priority moves to the other requester.
- Undefined: fixed priority, requester 0 always wins, and the RR pointer is absent.

## Test plan
- Single op: req0 issues 0x0000_0005 at T → `pipe_valid_in` at T+1; bench pipeline model returns 0xAB at T+5 → `resp0_valid=1`, `resp_data=0xAB` at T+6, `resp1_valid=0`.
- Contention: both valid for 4 cycles → with RR, grants go 0,1,0,1 and responses return in that order; without the macro, grants go 0,0,0,0 and req1 is starved.
- Flush: issue 3 back-to-back ops, assert `pipe_flush` 2 cycles after the first issue → `drop_count=2` (the third op was still in the issue register), no responses for the flushed ops, `sync_err=0`.
- Drain: `drain_req=1` with 2 ops in flight → readies 0, state=DRAIN, both responses delivered, state=HALT and `drain_done=1` the following cycle; `drain_req=0` → RUN.
- Spurious result: `pipe_valid_out=1` with an empty tag register → `sync_err=1` and it stays set; `rst` → all outputs 0.
- Saturation: preload by forcing CNT_WIDTH=4 and flush 16 full pipelines → `drop_count=0xF`.

Source files
------------

// File: rtl/pipe_issue_arbiter.sv
// Two-requester issue arbiter for a fixed-latency pipeline: tags in-flight ops, routes results,
// counts flushed ops and handles drain/halt. Define PIPE_ARB_RR_EN for round-robin arbitration.
module pipe_issue_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int PIPE_LATENCY = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  pipe_valid_in,
    output logic [DATA_WIDTH-1:0] pipe_data_in,
    input  logic                  pipe_valid_out,
    input  logic [DATA_WIDTH-1:0] pipe_data_out,
    input  logic                  pipe_flush,
    output logic                  resp0_valid,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic [1:0]            state,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  sync_err
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALT = 2'd2} state_e;
    localparam int PC_W = 4;

    function automatic logic [PC_W-1:0] popcount(input logic [PIPE_LATENCY-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < PIPE_LATENCY; i++) n = n + {{(PC_W-1){1'b0}}, v[i]};
        return n;
    endfunction

    state_e                   state_q, state_d;
    logic                     drain_done_q, drain_done_d;
    logic                     pipe_valid_in_q, pipe_valid_in_d;
    logic [DATA_WIDTH-1:0]    pipe_data_in_q, pipe_data_in_d;
    logic                     issue_id_q, issue_id_d;
    logic [PIPE_LATENCY-1:0]  tag_vld_q, tag_vld_d;
    logic [PIPE_LATENCY-1:0]  tag_id_q, tag_id_d;
    logic                     resp0_valid_q, resp0_valid_d;
    logic                     resp1_valid_q, resp1_valid_d;
    logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic [CNT_WIDTH-1:0]     drop_count_q, drop_count_d;
    logic                     sync_err_q, sync_err_d;
    logic                     grant0_s, grant1_s, accept_ok_s, hs0_s, hs1_s, empty_s;
    logic                     tail_vld_s, tail_id_s;
    logic [CNT_WIDTH+PC_W-1:0] drop_sum_s;
`ifdef PIPE_ARB_RR_EN
    logic                     prio_q, prio_d;
`endif

    // Arbitration and combinational readiness
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
`ifdef PIPE_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            grant0_s = !prio_q;
            grant1_s = prio_q;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
`else
        grant0_s = req0_valid;
        grant1_s = req1_valid && !req0_valid;
`endif
        accept_ok_s = (state_q == ST_RUN) && !drain_req;
        req0_ready  = accept_ok_s && grant0_s;
        req1_ready  = accept_ok_s && grant1_s;
        hs0_s       = req0_valid && req0_ready;
        hs1_s       = req1_valid && req1_ready;
    end

    // Next-state for issue register, tags, responses, counters and the drain FSM
    always_comb begin
        pipe_valid_in_d = hs0_s || hs1_s;
        pipe_data_in_d  = pipe_data_in_q;
        issue_id_d      = issue_id_q;
        if (hs0_s) begin
            pipe_data_in_d = req0_data;
            issue_id_d     = 1'b0;
        end else if (hs1_s) begin
            pipe_data_in_d = req1_data;
            issue_id_d     = 1'b1;
        end else begin
            pipe_data_in_d = pipe_data_in_q;
        end
`ifdef PIPE_ARB_RR_EN
        prio_d = prio_q;
        if (hs0_s) prio_d = 1'b1;
        else if (hs1_s) prio_d = 1'b0;
        else prio_d = prio_q;
`endif
        tail_vld_s = tag_vld_q[PIPE_LATENCY-1];
        tail_id_s  = tag_id_q[PIPE_LATENCY-1];
        tag_id_d   = {tag_id_q[PIPE_LATENCY-2:0], issue_id_q};
        // A flush also discards whatever sits in the issue register this cycle
        if (pipe_flush) tag_vld_d = '0;
        else tag_vld_d = {tag_vld_q[PIPE_LATENCY-2:0], pipe_valid_in_q};

        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        resp_data_d   = resp_data_q;
        if (!pipe_flush && tail_vld_s && pipe_valid_out) begin
            resp0_valid_d = !tail_id_s;
            resp1_valid_d = tail_id_s;
            resp_data_d   = pipe_data_out;
        end else begin
            resp_data_d = resp_data_q;
        end
        sync_err_d = sync_err_q || (!pipe_flush && (tail_vld_s != pipe_valid_out));

        drop_sum_s = {{PC_W{1'b0}}, drop_count_q} + {{CNT_WIDTH{1'b0}}, popcount(tag_vld_q)};
        if (!pipe_flush) drop_count_d = drop_count_q;
        else if (|drop_sum_s[CNT_WIDTH+PC_W-1:CNT_WIDTH]) drop_count_d = '1;
        else drop_count_d = drop_sum_s[CNT_WIDTH-1:0];

        empty_s = !(|tag_vld_q) && !pipe_valid_in_q;
        case (state_q)
            ST_RUN:   state_d = drain_req ? ST_DRAIN : ST_RUN;
            ST_DRAIN: begin
                if (!drain_req) state_d = ST_RUN;
                else if (empty_s) state_d = ST_HALT;
                else state_d = ST_DRAIN;
            end
            ST_HALT:  state_d = drain_req ? ST_HALT : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        drain_done_d = (state_d == ST_HALT);
    end

    // State and registered outputs; rst aborts all in-flight tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            drain_done_q    <= 1'b0;
            pipe_valid_in_q <= 1'b0;
            pipe_data_in_q  <= '0;
            issue_id_q      <= 1'b0;
            tag_vld_q       <= '0;
            tag_id_q        <= '0;
            resp0_valid_q   <= 1'b0;
            resp1_valid_q   <= 1'b0;
            resp_data_q     <= '0;
            drop_count_q    <= '0;
            sync_err_q      <= 1'b0;
`ifdef PIPE_ARB_RR_EN
            prio_q          <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            drain_done_q    <= drain_done_d;
            pipe_valid_in_q <= pipe_valid_in_d;
            pipe_data_in_q  <= pipe_data_in_d;
            issue_id_q      <= issue_id_d;
            tag_vld_q       <= tag_vld_d;
            tag_id_q        <= tag_id_d;
            resp0_valid_q   <= resp0_valid_d;
            resp1_valid_q   <= resp1_valid_d;
            resp_data_q     <= resp_data_d;
            drop_count_q    <= drop_count_d;
            sync_err_q      <= sync_err_d;
`ifdef PIPE_ARB_RR_EN
            prio_q          <= prio_d;
`endif
        end
    end

    assign pipe_valid_in = pipe_valid_in_q;
    assign pipe_data_in  = pipe_data_in_q;
    assign resp0_valid   = resp0_valid_q;
    assign resp1_valid   = resp1_valid_q;
    assign resp_data     = resp_data_q;
    assign drain_done    = drain_done_q;
    assign state         = state_q;
    assign drop_count    = drop_count_q;
    assign sync_err      = sync_err_q;
endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed bench for pipe_issue_arbiter with a 4-cycle pipeline model that returns operand + 0xA6.
module tb_pipe_issue_arbiter;
    localparam int DW = 32;
    localparam int LAT = 4;
    localparam int CW = 4;
`ifdef PIPE_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk, rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [DW-1:0] req0_data, req1_data;
    logic          pipe_valid_in, pipe_valid_out, pipe_flush;
    logic [DW-1:0] pipe_data_in, pipe_data_out;
    logic          resp0_valid, resp1_valid, drain_req, drain_done, sync_err;
    logic [DW-1:0] resp_data;
    logic [1:0]    state;
    logic [CW-1:0] drop_count;
    logic          spur;
    logic [LAT-1:0] pv_q;
    logic [DW-1:0]  pd_q [LAT];
    int n_checks = 0;
    int n_fail = 0;

    pipe_issue_arbiter #(.DATA_WIDTH(DW), .PIPE_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .pipe_valid_in(pipe_valid_in), .pipe_data_in(pipe_data_in),
        .pipe_valid_out(pipe_valid_out), .pipe_data_out(pipe_data_out),
        .pipe_flush(pipe_flush),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
        .drain_req(drain_req), .drain_done(drain_done), .state(state),
        .drop_count(drop_count), .sync_err(sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pipeline model: valid chain cleared by flush, data chain adds 0xA6
    always @(posedge clk or posedge rst) begin
        if (rst) pv_q <= '0;
        else if (pipe_flush) pv_q <= '0;
        else pv_q <= {pv_q[LAT-2:0], pipe_valid_in};
    end

    always @(posedge clk) begin
        pd_q[0] <= pipe_data_in + 32'hA6;
        for (int k = 1; k < LAT; k++) pd_q[k] <= pd_q[k-1];
    end

    assign pipe_valid_out = pv_q[LAT-1] | spur;
    assign pipe_data_out  = pd_q[LAT-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check_val({pfx, ".pvi"},   32'(pipe_valid_in), 32'd0);
        check_val({pfx, ".pdi"},   pipe_data_in,       32'd0);
        check_val({pfx, ".resp"},  32'({resp0_valid, resp1_valid}), 32'd0);
        check_val({pfx, ".rdata"}, resp_data,          32'd0);
        check_val({pfx, ".state"}, 32'(state),         32'd0);
        check_val({pfx, ".done"},  32'(drain_done),    32'd0);
        check_val({pfx, ".drops"}, 32'(drop_count),    32'd0);
        check_val({pfx, ".serr"},  32'(sync_err),      32'd0);
        check_val({pfx, ".rdy"},   32'({req0_ready, req1_ready}), 32'd0);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_d [4];
        logic        exp_g [4];
        rst = 1'b1; spur = 1'b0; pipe_flush = 1'b0; drain_req = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
        repeat (2) cyc();
        check_idle("reset");
        rst = 1'b0;
        cyc();

        // Contention: both requesters valid for four cycles
        for (int i = 0; i < 4; i++) begin
            exp_g[i] = RR_MODE ? i[0] : 1'b0;
            exp_d[i] = exp_g[i] ? 32'h200 + 32'(i) : 32'h100 + 32'(i);
            req0_valid = 1'b1; req0_data = 32'h100 + 32'(i);
            req1_valid = 1'b1; req1_data = 32'h200 + 32'(i);
            #1;
            check_val("cont.rdy0", 32'(req0_ready), 32'(!exp_g[i]));
            check_val("cont.rdy1", 32'(req1_ready), 32'(exp_g[i]));
            cyc();
            check_val("cont.pvi", 32'(pipe_valid_in), 32'd1);
            check_val("cont.pdi", pipe_data_in, exp_d[i]);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) begin
            check_val("cont.resp0", 32'(resp0_valid), 32'(!exp_g[i]));
            check_val("cont.resp1", 32'(resp1_valid), 32'(exp_g[i]));
            check_val("cont.rdata", resp_data, exp_d[i] + 32'hA6);
            cyc();
        end
        check_val("cont.quiet", 32'({resp0_valid, resp1_valid}), 32'd0);

        // Single op: 5 in, 0xAB back six cycles after acceptance
        req0_valid = 1'b1; req0_data = 32'h0000_0005;
        #1 check_val("single.rdy0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        check_val("single.pvi", 32'(pipe_valid_in), 32'd1);
        check_val("single.pdi", pipe_data_in, 32'h5);
        repeat (4) cyc();
        check_val("single.early", 32'(resp0_valid), 32'd0);
        cyc();
        check_val("single.resp0", 32'(resp0_valid), 32'd1);
        check_val("single.resp1", 32'(resp1_valid), 32'd0);
        check_val("single.rdata", resp_data, 32'hAB);
        cyc();
        check_val("single.after", 32'(resp0_valid), 32'd0);

        // Flush two cycles after the first of three back-to-back issues
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_data = 32'h30 + 32'(i);
            cyc();
        end
        req0_valid = 1'b0; pipe_flush = 1'b1;
        cyc();
        pipe_flush = 1'b0;
        check_val("flush.drops", 32'(drop_count), 32'd2);
        for (int i = 0; i < 7; i++) begin
            cyc();
            check_val("flush.noresp", 32'({resp0_valid, resp1_valid}), 32'd0);
        end
        check_val("flush.serr", 32'(sync_err), 32'd0);

        // Drain with two ops in flight
        req0_valid = 1'b1; req0_data = 32'h40;
        #1 check_val("drain.rdy_pre", 32'(req0_ready), 32'd1);
        cyc();
        req0_data = 32'h41;
        cyc();
        req0_data = 32'h42; drain_req = 1'b1;
        #1 check_val("drain.blocked", 32'(req0_ready), 32'd0);
        check_val("drain.st_run", 32'(state), 32'd0);
        cyc();
        check_val("drain.st_drain", 32'(state), 32'd1);
        check_val("drain.rdy", 32'(req0_ready), 32'd0);
        repeat (3) cyc();
        check_val("drain.resp_a", 32'(resp0_valid), 32'd1);
        check_val("drain.data_a", resp_data, 32'hE6);
        cyc();
        check_val("drain.resp_b", 32'(resp0_valid), 32'd1);
        check_val("drain.data_b", resp_data, 32'hE7);
        check_val("drain.st_b", 32'(state), 32'd1);
        check_val("drain.done_b", 32'(drain_done), 32'd0);
        cyc();
        check_val("drain.st_halt", 32'(state), 32'd2);
        check_val("drain.done", 32'(drain_done), 32'd1);
        check_val("drain.rdy_halt", 32'(req0_ready), 32'd0);
        drain_req = 1'b0; req0_valid = 1'b0;
        cyc();
        check_val("drain.st_back", 32'(state), 32'd0);
        check_val("drain.done_back", 32'(drain_done), 32'd0);

        // Spurious result with empty tags, then reset mid-operation
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        check_val("spur.serr", 32'(sync_err), 32'd1);
        check_val("spur.noresp", 32'({resp0_valid, resp1_valid}), 32'd0);
        repeat (2) cyc();
        check_val("spur.sticky", 32'(sync_err), 32'd1);
        req0_valid = 1'b1; req0_data = 32'h55;
        cyc();
        req0_valid = 1'b0;
        check_val("spur.pvi", 32'(pipe_valid_in), 32'd1);
        #2 rst = 1'b1;
        #1 check_idle("midrst");
        cyc();
        rst = 1'b0;
        cyc();

        // Saturation: flush sixteen full pipelines into a 4-bit counter
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j < 5; j++) begin
                req0_valid = 1'b1; req0_data = 32'(j);
                cyc();
            end
            req0_valid = 1'b0; pipe_flush = 1'b1;
            cyc();
            pipe_flush = 1'b0;
            check_val("sat.drops", 32'(drop_count), (r < 3) ? 32'(4 * (r + 1)) : 32'hF);
        end
        check_val("sat.serr", 32'(sync_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
